mode_record: RTL

- Record mode for the piano: the player enters a tune on the seven note switches and this block writes it into a packed song buffer.
- The buffer uses the same slot format that mode_learn consumes: 4-bit note code per slot plus 2-bit octave per slot, rest slots (4'b0000) between notes, and an end marker (4'b1111).
- Sits beside the song library. Its packed outputs feed the library as a user song slot, so a recorded tune can be replayed or learned.

---
 rtl/mode_record.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mode_record.sv
// Record mode: debounces the note switches and writes the played tune into a
// packed slot buffer (note code + octave per slot, rests between notes, end marker).
module mode_record #(
   parameter int SONG_TIME = 56,
   parameter int DEBOUNCE  = 1000000,
   parameter int CNT_W     = 20
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     record_en,
   input  logic [6:0]               switches,
   input  logic [1:0]               octave_in,
   output logic [SONG_TIME*4-1:0]   song_packed,
   output logic [SONG_TIME*2-1:0]   octave_packed,
   output logic [5:0]               length,
   output logic                     recording,
   output logic                     done,
   output logic                     full,
   output logic [6:0]               led_out
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_PRESS,
      ST_WAIT_RELEASE,
      ST_DONE
   } state_t;

   localparam logic [5:0]       LEN_MAX = 6'(SONG_TIME - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

   state_t                   state_q, state_d;
   logic [6:0]               sw_reg_q, sw_reg_d;
   logic [6:0]               sw_prev_q, sw_prev_d;
   logic [6:0]               sw_db_q, sw_db_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     prev_en_q, prev_en_d;
   logic [SONG_TIME*4-1:0]   song_q, song_d;
   logic [SONG_TIME*2-1:0]   oct_q, oct_d;
   logic [5:0]               length_q, length_d;
   logic                     full_q, full_d;
   logic [6:0]               led_q, led_d;

   logic [3:0] note_code;
   logic       onehot;
   logic       rise, fall;
   logic       wr_en;
   logic [3:0] wr_note;
   logic [1:0] wr_oct;

   // Counter restarts on any change between successive registered samples.
   always_comb begin
      sw_reg_d  = switches;
      sw_prev_d = sw_reg_q;
      sw_db_d   = sw_db_q;
      cnt_d     = cnt_q;
      if (sw_reg_q != sw_prev_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         sw_db_d = sw_reg_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      note_code = '0;
      for (int unsigned k = 0; k < 7; k++) begin
         if (sw_db_q[k]) note_code = 4'(k + 1);
      end
      onehot = (sw_db_q != '0) && ((sw_db_q & (sw_db_q - 7'd1)) == '0);
   end

   always_comb begin
      state_d   = state_q;
      song_d    = song_q;
      oct_d     = oct_q;
      length_d  = length_q;
      full_d    = full_q;
      led_d     = led_q;
      prev_en_d = record_en;
      rise      = record_en & ~prev_en_q;
      fall      = ~record_en & prev_en_q;
      wr_en     = 1'b0;
      wr_note   = '0;
      wr_oct    = '0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (rise) begin
               song_d   = '1;
               oct_d    = '0;
               length_d = '0;
               full_d   = 1'b0;
               led_d    = '0;
               state_d  = ST_WAIT_PRESS;
            end
         end
         ST_WAIT_PRESS: begin
            if (fall) begin
               song_d[{length_q, 2'b00} +: 4] = 4'hF;
               state_d = ST_DONE;
            end else if (onehot) begin
               wr_en   = 1'b1;
               wr_note = note_code;
               wr_oct  = octave_in;
               led_d   = sw_db_q;
               state_d = ST_WAIT_RELEASE;
            end
         end
         ST_WAIT_RELEASE: begin
            if (fall) begin
               song_d[{length_q, 2'b00} +: 4] = 4'hF;
               state_d = ST_DONE;
            end else if (sw_db_q == '0) begin
               wr_en   = 1'b1;
               led_d   = '0;
               state_d = ST_WAIT_PRESS;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The last slot is reserved for the end marker, so a write there ends the take.
      if (wr_en) begin
         if (length_q == LEN_MAX) begin
            song_d[{length_q, 2'b00} +: 4] = 4'hF;
            oct_d[{length_q, 1'b0} +: 2]   = 2'b00;
            full_d  = 1'b1;
            state_d = ST_DONE;
         end else begin
            song_d[{length_q, 2'b00} +: 4] = wr_note;
            oct_d[{length_q, 1'b0} +: 2]   = wr_oct;
            length_d = length_q + 6'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         sw_reg_q  <= '0;
         sw_prev_q <= '0;
         sw_db_q   <= '0;
         cnt_q     <= '0;
         prev_en_q <= 1'b0;
         song_q    <= '1;
         oct_q     <= '0;
         length_q  <= '0;
         full_q    <= 1'b0;
         led_q     <= '0;
      end else begin
         state_q   <= state_d;
         sw_reg_q  <= sw_reg_d;
         sw_prev_q <= sw_prev_d;
         sw_db_q   <= sw_db_d;
         cnt_q     <= cnt_d;
         prev_en_q <= prev_en_d;
         song_q    <= song_d;
         oct_q     <= oct_d;
         length_q  <= length_d;
         full_q    <= full_d;
         led_q     <= led_d;
      end
   end

   assign song_packed   = song_q;
   assign octave_packed = oct_q;
   assign length        = length_q;
   assign recording     = (state_q == ST_WAIT_PRESS) || (state_q == ST_WAIT_RELEASE);
   assign done          = (state_q == ST_DONE);
   assign full          = full_q;
   assign led_out       = led_q;

endmodule
